// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between the master FSM and the register-file completer.
interface apb_regfile_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB completer: word-addressed register file with a read-only ID register
// at index 0, a fixed number of wait states per transfer and PSLVERR on bad
// accesses. Address, direction, data and the error decision are captured in
// the setup phase and used for the whole transfer.
module apb_regfile_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_regfile_slave_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [5:0]  idx_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;

  logic        latch_en;
  logic        ready;
  logic        commit;
  logic        setup_err;
  logic [31:0] rd_data;

  // Entry 0 is the constant ID register, so only 1..NUM_REGS-1 hold state.
  logic [31:0] regs_reg [1:NUM_REGS-1];

  // Error decision made from the setup-phase address/direction.
  assign setup_err = (bus.PADDR[1:0] != 2'b00)
                  || ({1'b0, bus.PADDR[7:2]} >= NUM_REGS_W)
                  || (bus.PWRITE && (bus.PADDR[7:2] == 6'd0));

  // Next-state, counter and completion decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          latch_en   = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL || !bus.PENABLE) begin
          // Master broke the protocol: abandon the transfer silently.
          state_next = IDLE;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          ready      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit = ready && write_reg && !err_reg;

  // State and wait counter registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture of the setup-phase request.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      idx_reg   <= 6'd0;
      write_reg <= 1'b0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else if (latch_en) begin
      idx_reg   <= bus.PADDR[7:2];
      write_reg <= bus.PWRITE;
      wdata_reg <= bus.PWDATA;
      err_reg   <= setup_err;
    end
  end

  // One write-enabled register per writable index.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
        regs_reg[gi] <= 32'd0;
      end else if (commit && (idx_reg == 6'(gi))) begin
        regs_reg[gi] <= wdata_reg;
      end
    end
  end

  // Read mux over the latched index; out-of-range indices are masked by err_reg.
  always_comb begin
    rd_data = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx_reg == 6'(i)) begin
        rd_data = regs_reg[i];
      end
    end
  end

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_reg;
  assign bus.PRDATA  = (ready && !err_reg && !write_reg) ? rd_data : 32'd0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: a vector table of single transfers
// on a WAIT_CYCLES=2 instance, plus hand sequences for a zero-wait instance,
// protocol abort, IDLE-phase PENABLE and reset in the middle of a write.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  // Shared master-side drive; sel0 steers it to the zero-wait instance.
  logic        sel0 = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;

  apb_regfile_slave_if bus ();
  apb_regfile_slave_if bus0 ();

  assign bus.PSEL     = psel && !sel0;
  assign bus.PENABLE  = penable;
  assign bus.PADDR    = paddr;
  assign bus.PWRITE   = pwrite;
  assign bus.PWDATA   = pwdata;
  assign bus0.PSEL    = psel && sel0;
  assign bus0.PENABLE = penable;
  assign bus0.PADDR   = paddr;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PWDATA  = pwdata;

  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;
  assign pready  = sel0 ? bus0.PREADY  : bus.PREADY;
  assign pslverr = sel0 ? bus0.PSLVERR : bus.PSLVERR;
  assign prdata  = sel0 ? bus0.PRDATA  : bus.PRDATA;

  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );

  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; returns the access cycle on which PREADY rose (0 = never).
  // PADDR/PWDATA are scrambled during ACCESS to confirm the setup values are used.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output int cyc, output logic [31:0] rd, output logic err);
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge PCLK);
    penable = 1'b1; paddr = 8'hFD; pwdata = ~d;
    cyc = 0; rd = 32'd0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (pready) begin
        cyc = i; rd = prdata; err = pslverr;
        break;
      end
      @(negedge PCLK);
    end
    @(posedge PCLK);
    $display("xfer %s addr=%h wdata=%h -> ready_cycle=%0d rdata=%h slverr=%0b",
             wr ? "WR" : "RD", a, d, cyc, rd, err);
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  int          cyc;
  logic [31:0] rd;
  logic        err;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 32'h0,         ID,            1'b0};
    vecs[1]  = '{1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 8'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b1, 8'h00, 32'h1111_2222, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 8'h40, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b0, 8'h05, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,         ID,            1'b0};
    vecs[8]  = '{1'b0, 8'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b1, 8'h3C, 32'h5A5A_0F0F, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 8'h3C, 32'h0,         32'h5A5A_0F0F, 1'b0};
    vecs[11] = '{1'b1, 8'h06, 32'h0000_0077, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 8'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_pready", {31'd0, bus.PREADY}, 32'd0);
    check("reset_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    check("reset_prdata", bus.PRDATA, 32'd0);
    PRESETn = 1'b1;

    // PENABLE without a setup phase must not start a transfer
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_penable_pready", {31'd0, pready}, 32'd0);
      @(negedge PCLK);
    end
    psel = 1'b0; penable = 1'b0;

    // Vector table, back-to-back on the WAIT_CYCLES=2 instance
    for (int v = 0; v < 13; v++) begin
      xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, cyc, rd, err);
      check($sformatf("vec%0d_cycle", v), 32'(cyc), 32'd3);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_slverr", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
    end
    go_idle();

    // Zero-wait instance: PREADY in the first access cycle
    sel0 = 1'b1;
    xfer(1'b1, 8'h0C, 32'h1234_5678, cyc, rd, err);
    check("w0_write_cycle", 32'(cyc), 32'd1);
    check("w0_write_slverr", {31'd0, err}, 32'd0);
    xfer(1'b0, 8'h0C, 32'h0, cyc, rd, err);
    check("w0_read_cycle", 32'(cyc), 32'd1);
    check("w0_read_rdata", rd, 32'h1234_5678);
    go_idle();
    sel0 = 1'b0;

    // PSEL dropped after one access cycle of a write
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hFFFF_FFFF;
    @(negedge PCLK);
    penable = 1'b1;
    #1 check("abort_acc1_pready", {31'd0, pready}, 32'd0);
    @(negedge PCLK);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("abort_after_pready", {31'd0, pready}, 32'd0);
      @(negedge PCLK);
    end
    $display("abort WR addr=10 wdata=ffffffff dropped after one access cycle");
    xfer(1'b0, 8'h10, 32'h0, cyc, rd, err);
    check("abort_read_cycle", 32'(cyc), 32'd3);
    check("abort_read_rdata", rd, 32'h0);
    go_idle();

    // Reset during the wait states of a write
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hCAFE_F00D;
    @(negedge PCLK);
    penable = 1'b1;
    #1 check("rst_acc1_pready", {31'd0, pready}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    #1 check("rst_next_pready", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    $display("reset asserted mid-write addr=14 wdata=cafef00d");
    xfer(1'b0, 8'h14, 32'h0, cyc, rd, err);
    check("rst_read14_cycle", 32'(cyc), 32'd3);
    check("rst_read14_rdata", rd, 32'h0);
    xfer(1'b0, 8'h04, 32'h0, cyc, rd, err);
    check("rst_read04_rdata", rd, 32'h0);
    xfer(1'b0, 8'h00, 32'h0, cyc, rd, err);
    check("rst_read00_rdata", rd, ID);
    go_idle();

    // Reset also cleared the zero-wait instance
    sel0 = 1'b1;
    xfer(1'b0, 8'h0C, 32'h0, cyc, rd, err);
    check("w0_rst_read_cycle", 32'(cyc), 32'd1);
    check("w0_rst_read_rdata", rd, 32'h0);
    go_idle();
    sel0 = 1'b0;

    repeat (2) @(posedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
